// File: rtl/fp_conv_pkg.sv
// Shared types and constants for the compact floating-point converter.
package fp_conv_pkg;

   localparam int unsigned FP_EXP_W = 3;
   localparam int unsigned FP_SIG_W = 4;
   localparam int unsigned FP_IN_W  = 12;

   localparam logic [FP_EXP_W-1:0] EXP_MAX  = '1;
   localparam logic [FP_SIG_W-1:0] SIG_ONES = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      NORM  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } fp_state_t;

   // Input width must exactly cover the exponent range plus the significand.
   function automatic bit fp_width_ok(input int unsigned exp_w,
                                      input int unsigned sig_w,
                                      input int unsigned in_w);
      return in_w == ((32'd1 << exp_w) + sig_w);
   endfunction

endpackage

// File: rtl/fp_round.sv
// Round-half-up of the normalised significand, with renormalise or saturate
// when the increment carries out of the significand.
module fp_round
   import fp_conv_pkg::*;
#(
   parameter int unsigned EXP_W = FP_EXP_W,
   parameter int unsigned SIG_W = FP_SIG_W
) (
   input  logic [SIG_W-1:0] i_f0,
   input  logic             i_r,
   input  logic [EXP_W-1:0] i_exp,
   output logic [EXP_W-1:0] o_e_c,
   output logic [SIG_W-1:0] o_f_c,
   output logic             o_ovf_sat_c
);

   localparam logic [EXP_W-1:0] L_EXP_MAX  = '1;
   localparam logic [SIG_W-1:0] L_SIG_ONES = '1;

   logic [SIG_W:0] w_f1;

   // Increment by the round bit; a carry-out means the significand hit 2^SIG_W.
   always_comb begin
      w_f1        = {1'b0, i_f0} + (SIG_W+1)'(i_r);
      o_e_c       = i_exp;
      o_f_c       = w_f1[SIG_W-1:0];
      o_ovf_sat_c = 1'b0;
      if (w_f1[SIG_W]) begin
         if (i_exp == L_EXP_MAX) begin
            o_f_c       = L_SIG_ONES;
            o_ovf_sat_c = 1'b1;
         end else begin
            o_e_c = i_exp + EXP_W'(1);
            o_f_c = {1'b1, {(SIG_W-1){1'b0}}};
         end
      end
   end

endmodule

// File: rtl/fp_convert_seq.sv
// Sequential two's-complement to (S, E, F) converter, value ~= F * 2^E.
// Optional macro FP_CONV_SAT_FLAG_EN adds a registered saturation flag port.
module fp_convert_seq
   import fp_conv_pkg::*;
#(
   parameter int unsigned EXP_W = FP_EXP_W,
   parameter int unsigned SIG_W = FP_SIG_W,
   parameter int unsigned IN_W  = FP_IN_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  d,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef FP_CONV_SAT_FLAG_EN
   output logic             sat,
`endif
   output logic             s,
   output logic [EXP_W-1:0] e,
   output logic [SIG_W-1:0] f
);

   localparam int unsigned MAG_W = IN_W - 1;
   localparam logic [EXP_W-1:0] L_EXP_MAX  = '1;
   localparam logic [SIG_W-1:0] L_SIG_ONES = '1;

   if (!fp_width_ok(EXP_W, SIG_W, IN_W)) begin : g_bad_width
      $error("fp_convert_seq: IN_W must equal 2**EXP_W + SIG_W");
   end

   fp_state_t r_state, w_state_nxt;

   logic [MAG_W-1:0] r_work, w_work_nxt;
   logic [EXP_W-1:0] r_exp, w_exp_nxt;
   logic             r_sign, w_sign_nxt;
   logic             r_sat, w_sat_nxt;
   logic             r_s, w_s_nxt;
   logic [EXP_W-1:0] r_e, w_e_nxt;
   logic [SIG_W-1:0] r_f, w_f_nxt;
   logic             r_out_valid, w_out_valid_nxt;
   logic             r_in_ready, w_in_ready_nxt;

   logic [MAG_W-1:0] w_mag;
   logic             w_sat_in;
   logic [EXP_W-1:0] w_rnd_e;
   logic [SIG_W-1:0] w_rnd_f;
   logic             w_ovf_sat;

   // Magnitude of the sample; the most negative code wraps to zero and is flagged.
   assign w_mag    = d[IN_W-1] ? ((~d[MAG_W-1:0]) + MAG_W'(1)) : d[MAG_W-1:0];
   assign w_sat_in = d[IN_W-1] & ~(|d[MAG_W-1:0]);

   fp_round #(
      .EXP_W (EXP_W),
      .SIG_W (SIG_W)
   ) u_round (
      .i_f0        (r_work[MAG_W-1 -: SIG_W]),
      .i_r         (r_work[MAG_W-1-SIG_W]),
      .i_exp       (r_exp),
      .o_e_c       (w_rnd_e),
      .o_f_c       (w_rnd_f),
      .o_ovf_sat_c (w_ovf_sat)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state and next-value logic for the datapath and handshakes.
   always_comb begin
      w_state_nxt     = r_state;
      w_work_nxt      = r_work;
      w_exp_nxt       = r_exp;
      w_sign_nxt      = r_sign;
      w_sat_nxt       = r_sat;
      w_s_nxt         = r_s;
      w_e_nxt         = r_e;
      w_f_nxt         = r_f;
      w_out_valid_nxt = r_out_valid;
      w_in_ready_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (in_valid && r_in_ready) begin
               w_sign_nxt  = d[IN_W-1];
               w_sat_nxt   = w_sat_in;
               w_work_nxt  = w_sat_in ? {MAG_W{1'b1}} : w_mag;
               w_exp_nxt   = L_EXP_MAX;
               w_state_nxt = NORM;
            end else begin
               w_in_ready_nxt = 1'b1;
            end
         end
         NORM: begin
            if (r_work[MAG_W-1] || (r_exp == '0)) begin
               w_state_nxt = ROUND;
            end else begin
               w_work_nxt = {r_work[MAG_W-2:0], 1'b0};
               w_exp_nxt  = r_exp - EXP_W'(1);
            end
         end
         ROUND: begin
            w_s_nxt         = r_sign;
            w_e_nxt         = r_sat ? L_EXP_MAX : w_rnd_e;
            w_f_nxt         = r_sat ? L_SIG_ONES : w_rnd_f;
            w_sat_nxt       = r_sat | w_ovf_sat;
            w_out_valid_nxt = 1'b1;
            w_state_nxt     = DONE;
         end
         DONE: begin
            if (out_ready) begin
               w_out_valid_nxt = 1'b0;
               w_in_ready_nxt  = 1'b1;
               w_state_nxt     = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_work      <= '0;
         r_exp       <= '0;
         r_sign      <= 1'b0;
         r_sat       <= 1'b0;
         r_s         <= 1'b0;
         r_e         <= '0;
         r_f         <= '0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b0;
      end else begin
         r_work      <= w_work_nxt;
         r_exp       <= w_exp_nxt;
         r_sign      <= w_sign_nxt;
         r_sat       <= w_sat_nxt;
         r_s         <= w_s_nxt;
         r_e         <= w_e_nxt;
         r_f         <= w_f_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_in_ready  <= w_in_ready_nxt;
      end
   end

`ifdef FP_CONV_SAT_FLAG_EN
   logic r_sat_out;

   // Saturation flag published together with s/e/f.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  r_sat_out <= 1'b0;
      else if (r_state == ROUND) r_sat_out <= w_sat_nxt;
   end

   assign sat = r_sat_out;
`endif

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign s         = r_s;
   assign e         = r_e;
   assign f         = r_f;

endmodule

// File: tb/tb_fp_convert_seq.sv
// Self-checking bench for fp_convert_seq against an arithmetic reference model.
module tb_fp_convert_seq;
   import fp_conv_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [11:0] d = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        s;
   logic [2:0]  e;
   logic [3:0]  f;
`ifdef FP_CONV_SAT_FLAG_EN
   logic        sat;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fp_convert_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .d         (d),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef FP_CONV_SAT_FLAG_EN
      .sat       (sat),
`endif
      .s         (s),
      .e         (e),
      .f         (f)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Value ~= F*2^E: pick the smallest E that fits the magnitude in 4 bits,
   // round half up, and renormalise or saturate on carry.
   task automatic ref_model(input logic [11:0] din, output int es, output int ee,
                            output int ef, output int esat, output int elat);
      int v, mag, p, e0, f1, rnd;
      v    = int'($signed(din));
      es   = (v < 0) ? 1 : 0;
      mag  = (v < 0) ? -v : v;
      esat = 0;
      if (mag >= 2048) begin
         ee = int'(EXP_MAX); ef = int'(SIG_ONES); esat = 1; elat = 2;
      end else begin
         p = -1;
         for (int i = 0; i < 11; i++) if (((mag >> i) & 1) == 1) p = i;
         e0   = (p > 3) ? p - 3 : 0;
         elat = (7 - e0) + 2;
         rnd  = (e0 > 0) ? (1 << (e0 - 1)) : 0;
         f1   = (mag + rnd) >> e0;
         if (f1 == 16) begin
            if (e0 < 7) begin ee = e0 + 1; ef = 8; end
            else begin ee = 7; ef = 15; esat = 1; end
         end else begin
            ee = e0; ef = f1;
         end
      end
   endtask

   // One full transaction; hold>0 keeps out_ready low that many cycles in DONE.
   task automatic convert(input logic [11:0] din, input int hold);
      int es, ee, ef, esat, elat, lat;
      ref_model(din, es, ee, ef, esat, elat);
      out_ready = (hold == 0);
      @(negedge clk);
      lat = 0;
      while (!in_ready && lat < 20) begin @(negedge clk); lat++; end
      if (!in_ready) begin chk("in_ready_timeout", 32'(in_ready), 32'd1); return; end
      d = din; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; d = 12'($urandom);
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!out_valid && lat < 20);
      chk($sformatf("latency d=%h", din), 32'(lat), 32'(elat));
      chk($sformatf("s d=%h", din), 32'(s), 32'(es));
      chk($sformatf("e d=%h", din), 32'(e), 32'(ee));
      chk($sformatf("f d=%h", din), 32'(f), 32'(ef));
`ifdef FP_CONV_SAT_FLAG_EN
      chk($sformatf("sat d=%h", din), 32'(sat), 32'(esat));
`endif
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         in_valid = 1'b1; d = 12'($urandom);
         chk("hold_sef", 32'({s, e, f}), 32'({es[0], ee[2:0], ef[3:0]}));
         chk("hold_out_valid", 32'(out_valid), 32'd1);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      if (hold > 0) begin
         @(negedge clk);
         in_valid = 1'b0; out_ready = 1'b1;
      end
      @(posedge clk); #1;
      chk("xfer_out_valid", 32'(out_valid), 32'd0);
      chk("xfer_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
   endtask

   initial begin
      logic seen;
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sef", 32'({s, e, f}), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Directed corner cases
      convert(12'b001000110010, 0);
      convert(12'h860, 0);
      convert(12'hFFF, 0);
      convert(12'h000, 0);
      convert(12'd124, 0);
      convert(12'h7FF, 0);
      convert(12'h800, 0);
      convert(12'b001000110010, 5);

      // Idle with no valid stays quiet
      repeat (4) @(posedge clk);
      #1 chk("idle_out_valid", 32'(out_valid), 32'd0);

      // Reset pulse while normalising discards the sample
      @(negedge clk);
      d = 12'd5; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd0);
      chk("midrst_sef", 32'({s, e, f}), 32'd0);
      @(negedge clk) rst = 1'b0;
      seen = 1'b0;
      repeat (12) begin @(posedge clk); #1 seen = seen | out_valid; end
      chk("midrst_no_output", 32'(seen), 32'd0);
      convert(12'd40, 0);
      chk("d40_e", 32'(e), 32'd2);
      chk("d40_f", 32'(f), 32'b1010);

      // Randomised conversions
      for (int i = 0; i < 60; i++) begin
         convert(12'($urandom), int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
